// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// ahb_sram_slave : AHB-Lite word SRAM slave with wait states and privilege gate
// Revision: 1.0
// ============================================================================
module ahb_sram_slave #(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned PRIV_WORDS  = 0
) (
   input  logic        hclk,
   input  logic        hreset_n,
   input  logic        hsel_s,
   input  logic [31:0] haddr_s,
   input  logic [1:0]  htrans_s,
   input  logic        hwrite_s,
   input  logic [2:0]  hsize_s,
   input  logic [3:0]  hprot_s,
   input  logic [31:0] hwdata_s,
   input  logic        hready_s,
   output logic        hreadyout_s,
   output logic        hresp_s,
   output logic [31:0] hrdata_s
);

   localparam int unsigned c_AW   = $clog2(MEM_WORDS);
   localparam logic [3:0]  c_WAIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [c_AW-1:0]   idx_q, idx_d;
   logic [3:0]        lanes_q, lanes_d;
   logic              write_q, write_d;
   logic [31:0]       mem_q [MEM_WORDS];

   logic              w_accept;
   logic              w_free;
   logic              w_illegal;
   logic              w_misaligned;
   logic              w_in_range;
   logic              w_priv_viol;
   logic              w_commit;
   logic [c_AW-1:0]   w_idx;
   logic [3:0]        w_lanes;
   logic              w_unused;

   assign w_accept     = hsel_s && hready_s && htrans_s[1];
   assign w_idx        = haddr_s[c_AW+1:2];
   assign w_in_range   = (haddr_s[31:c_AW+2] == BASE_ADDR[31:c_AW+2]);
   assign w_misaligned = ((hsize_s == 3'd1) && haddr_s[0]) ||
                         ((hsize_s == 3'd2) && (haddr_s[1:0] != 2'b00));
   assign w_illegal    = (hsize_s > 3'd2) || w_misaligned || !w_in_range || w_priv_viol;
   assign w_unused     = ^{hprot_s, htrans_s[0]};

   generate
      if (PRIV_WORDS > 0) begin : g_priv
         assign w_priv_viol = (32'(w_idx) < PRIV_WORDS) && !hprot_s[1];
      end else begin : g_no_priv
         assign w_priv_viol = 1'b0;
      end
   endgenerate

   always_comb begin
      w_lanes = 4'b1111;
      case (hsize_s)
         3'd0:    w_lanes = 4'b0001 << haddr_s[1:0];
         3'd1:    w_lanes = haddr_s[1] ? 4'b1100 : 4'b0011;
         default: w_lanes = 4'b1111;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      lanes_d     = lanes_q;
      write_d     = write_q;
      w_free      = 1'b0;
      hreadyout_s = 1'b1;
      hresp_s     = 1'b0;
      case (state_q)
         S_IDLE: w_free = 1'b1;
         S_DATA: begin
            hreadyout_s = (cnt_q == 4'd0);
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               w_free = 1'b1;
         end
         S_ERR1: begin
            hreadyout_s = 1'b0;
            hresp_s     = 1'b1;
            state_d     = S_ERR2;
         end
         S_ERR2: begin
            hresp_s = 1'b1;
            w_free  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // A new address phase can only be taken once the current data phase ends.
      if (w_free) begin
         if (w_accept) begin
            idx_d   = w_idx;
            lanes_d = w_lanes;
            write_d = hwrite_s;
            cnt_d   = c_WAIT;
            state_d = w_illegal ? S_ERR1 : S_DATA;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         lanes_q <= 4'd0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lanes_q <= lanes_d;
         write_q <= write_d;
      end
   end

   // Only legal transfers reach DATA, so erroring writes never commit.
   assign w_commit = (state_q == S_DATA) && (cnt_q == 4'd0) && write_q;

   always_ff @(posedge hclk) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes_q[b]) mem_q[idx_q][8*b +: 8] <= hwdata_s[8*b +: 8];
         end
      end
   end

   assign hrdata_s = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_ahb_sram_slave : directed bench over three slave configurations
// Revision: 1.0
// ============================================================================
module tb_ahb_sram_slave;

   logic        hclk = 1'b0;
   logic        hreset_n;
   logic        sel_a, sel_b, sel_c;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        ro_a, ro_b, ro_c;
   logic        rs_a, rs_b, rs_c;
   logic [31:0] rd_a, rd_b, rd_c;

   int checks = 0;
   int errors = 0;

   always #5 hclk = ~hclk;

   // A: zero-wait with four privileged words; B: three waits; C: two waits.
   ahb_sram_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0), .PRIV_WORDS(4)) u_a (
      .hclk(hclk), .hreset_n(hreset_n), .hsel_s(sel_a), .haddr_s(haddr), .htrans_s(htrans),
      .hwrite_s(hwrite), .hsize_s(hsize), .hprot_s(hprot), .hwdata_s(hwdata), .hready_s(ro_a),
      .hreadyout_s(ro_a), .hresp_s(rs_a), .hrdata_s(rd_a));

   ahb_sram_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3), .PRIV_WORDS(0)) u_b (
      .hclk(hclk), .hreset_n(hreset_n), .hsel_s(sel_b), .haddr_s(haddr), .htrans_s(htrans),
      .hwrite_s(hwrite), .hsize_s(hsize), .hprot_s(hprot), .hwdata_s(hwdata), .hready_s(ro_b),
      .hreadyout_s(ro_b), .hresp_s(rs_b), .hrdata_s(rd_b));

   ahb_sram_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2), .PRIV_WORDS(0)) u_c (
      .hclk(hclk), .hreset_n(hreset_n), .hsel_s(sel_c), .haddr_s(haddr), .htrans_s(htrans),
      .hwrite_s(hwrite), .hsize_s(hsize), .hprot_s(hprot), .hwdata_s(hwdata), .hready_s(ro_c),
      .hreadyout_s(ro_c), .hresp_s(rs_c), .hrdata_s(rd_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic ap(input logic [2:0] sel, input logic [31:0] a, input logic w,
                     input logic [2:0] sz, input logic [3:0] prot);
      {sel_a, sel_b, sel_c} = sel;
      haddr  = a;
      htrans = 2'b10;
      hwrite = w;
      hsize  = sz;
      hprot  = prot;
   endtask

   task automatic idle_bus();
      {sel_a, sel_b, sel_c} = 3'b000;
      htrans = 2'b00;
   endtask

   localparam logic [2:0] c_A = 3'b100;
   localparam logic [2:0] c_B = 3'b010;
   localparam logic [2:0] c_C = 3'b001;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      hreset_n = 1'b0;
      hwdata   = 32'd0;
      haddr    = 32'd0;
      hwrite   = 1'b0;
      hsize    = 3'd0;
      hprot    = 4'd0;
      idle_bus();
      #2;
      chk("rst_rdy_a", 32'(ro_a), 32'd1);
      chk("rst_resp_a", 32'(rs_a), 32'd0);
      chk("rst_data_a", rd_a, 32'd0);
      chk("rst_rdy_b", 32'(ro_b), 32'd1);
      cyc(); cyc();
      hreset_n = 1'b1;

      // Back-to-back word write then read, zero waits
      cyc(); ap(c_A, 32'h1010, 1'b1, 3'd2, 4'd0);
      cyc(); hwdata = 32'hDEAD_BEEF; ap(c_A, 32'h1010, 1'b0, 3'd2, 4'd0);
      chk("a_wr_rdy", 32'(ro_a), 32'd1);
      cyc(); idle_bus();
      chk("a_rd_rdy", 32'(ro_a), 32'd1);
      chk("a_rd_resp", 32'(rs_a), 32'd0);
      chk("a_rd_data", rd_a, 32'hDEAD_BEEF);

      // Byte then half lane writes
      cyc(); chk("a_idle_data", rd_a, 32'd0); ap(c_A, 32'h1010, 1'b1, 3'd2, 4'd0);
      cyc(); hwdata = 32'h1122_3344; ap(c_A, 32'h1013, 1'b1, 3'd0, 4'd0);
      cyc(); hwdata = 32'hAA5A_5A5A; ap(c_A, 32'h1010, 1'b0, 3'd2, 4'd0);
      cyc(); idle_bus();
      chk("a_byte_wr", rd_a, 32'hAA22_3344);
      cyc(); ap(c_A, 32'h1010, 1'b1, 3'd1, 4'd0);
      cyc(); hwdata = 32'h9999_5566; ap(c_A, 32'h1011, 1'b0, 3'd0, 4'd0);
      cyc(); idle_bus();
      chk("a_half_wr", rd_a, 32'hAA22_5566);

      // Misaligned word write errors and leaves memory alone
      cyc(); ap(c_A, 32'h1000, 1'b1, 3'd2, 4'b0010);
      cyc(); hwdata = 32'hCAFE_F00D; ap(c_A, 32'h1002, 1'b1, 3'd2, 4'b0010);
      cyc(); hwdata = 32'h1234_5678; idle_bus();
      chk("a_err1_rdy", 32'(ro_a), 32'd0);
      chk("a_err1_resp", 32'(rs_a), 32'd1);
      cyc();
      chk("a_err2_rdy", 32'(ro_a), 32'd1);
      chk("a_err2_resp", 32'(rs_a), 32'd1);
      ap(c_A, 32'h1000, 1'b0, 3'd2, 4'b0010);
      cyc(); idle_bus();
      chk("a_err_rd_resp", 32'(rs_a), 32'd0);
      chk("a_err_nochg", rd_a, 32'hCAFE_F00D);

      // Privileged region: user write rejected, privileged write stored
      cyc(); ap(c_A, 32'h1008, 1'b1, 3'd2, 4'b0010);
      cyc(); hwdata = 32'h0BAD_C0DE; ap(c_A, 32'h1008, 1'b1, 3'd2, 4'b0000);
      cyc(); hwdata = 32'h7777_7777; idle_bus();
      chk("a_priv_err1_rdy", 32'(ro_a), 32'd0);
      chk("a_priv_err1_resp", 32'(rs_a), 32'd1);
      cyc();
      chk("a_priv_err2_resp", 32'(rs_a), 32'd1);
      ap(c_A, 32'h1008, 1'b0, 3'd2, 4'b0010);
      cyc(); ap(c_A, 32'h1008, 1'b1, 3'd2, 4'b0010);
      chk("a_priv_keep", rd_a, 32'h0BAD_C0DE);
      cyc(); hwdata = 32'h7777_7777; ap(c_A, 32'h1008, 1'b0, 3'd2, 4'b0010);
      chk("a_priv_ok_resp", 32'(rs_a), 32'd0);
      cyc(); idle_bus();
      chk("a_priv_store", rd_a, 32'h7777_7777);

      // Out of range, then oversize
      cyc(); ap(c_A, 32'h1040, 1'b0, 3'd2, 4'b0010);
      cyc(); idle_bus();
      chk("a_oor_resp", 32'(rs_a), 32'd1);
      cyc(); ap(c_A, 32'h1000, 1'b0, 3'd3, 4'b0010);
      cyc(); idle_bus();
      chk("a_size_resp", 32'(rs_a), 32'd1);
      cyc(); sel_a = 1'b1; htrans = 2'b00;
      cyc();
      chk("a_idle_tr_rdy", 32'(ro_a), 32'd1);
      chk("a_idle_tr_resp", 32'(rs_a), 32'd0);
      idle_bus();

      // Three wait states; a held illegal phase must wait for hready
      cyc(); ap(c_B, 32'h1010, 1'b1, 3'd2, 4'd0);
      cyc(); hwdata = 32'h600D_CAFE; idle_bus();
      chk("b_wwait1", 32'(ro_b), 32'd0);
      cyc(); chk("b_wwait2", 32'(ro_b), 32'd0);
      cyc(); chk("b_wwait3", 32'(ro_b), 32'd0);
      cyc(); chk("b_wdone", 32'(ro_b), 32'd1);
      ap(c_B, 32'h1010, 1'b0, 3'd2, 4'd0);
      cyc(); ap(c_B, 32'h1011, 1'b1, 3'd2, 4'd0);
      chk("b_rwait1_rdy", 32'(ro_b), 32'd0);
      chk("b_rwait1_resp", 32'(rs_b), 32'd0);
      cyc(); chk("b_rwait2_rdy", 32'(ro_b), 32'd0);
      cyc();
      chk("b_rwait3_rdy", 32'(ro_b), 32'd0);
      chk("b_rwait3_resp", 32'(rs_b), 32'd0);
      cyc();
      chk("b_rdone_rdy", 32'(ro_b), 32'd1);
      chk("b_rdone_data", rd_b, 32'h600D_CAFE);
      cyc(); idle_bus();
      chk("b_err1_rdy", 32'(ro_b), 32'd0);
      chk("b_err1_resp", 32'(rs_b), 32'd1);
      cyc();
      chk("b_err2_rdy", 32'(ro_b), 32'd1);
      chk("b_err2_resp", 32'(rs_b), 32'd1);
      cyc();
      chk("b_end_resp", 32'(rs_b), 32'd0);

      // Two wait states, reset pulsed during a read wait cycle
      cyc(); ap(c_C, 32'h1000, 1'b1, 3'd2, 4'd0);
      cyc(); hwdata = 32'hFEED_FACE; idle_bus();
      cyc();
      cyc(); chk("c_wdone", 32'(ro_c), 32'd1);
      ap(c_C, 32'h1000, 1'b0, 3'd2, 4'd0);
      cyc(); idle_bus();
      chk("c_rwait_rdy", 32'(ro_c), 32'd0);
      chk("c_rwait_data", rd_c, 32'hFEED_FACE);
      #2; hreset_n = 1'b0;
      #1;
      chk("c_rst_rdy", 32'(ro_c), 32'd1);
      chk("c_rst_resp", 32'(rs_c), 32'd0);
      chk("c_rst_data", rd_c, 32'd0);
      cyc(); cyc();
      hreset_n = 1'b1;
      cyc(); sel_c = 1'b1; htrans = 2'b00;
      chk("c_post_rdy", 32'(ro_c), 32'd1);
      cyc();
      chk("c_idle_tr_rdy", 32'(ro_c), 32'd1);
      chk("c_idle_tr_resp", 32'(rs_c), 32'd0);
      ap(c_C, 32'h1000, 1'b0, 3'd2, 4'd0);
      cyc(); idle_bus();
      cyc();
      cyc();
      chk("c_keep_rdy", 32'(ro_c), 32'd1);
      chk("c_keep_data", rd_c, 32'hFEED_FACE);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite slave with an internal word-organised SRAM and a configurable number of wait states. It sits directly downstream of the OBI-to-AHB master adapter on the data bus and serves core loads and stores. It decodes HSIZE and HADDR into byte lanes and blocks user-mode access to a privileged low region. It returns the two-cycle AHB ERROR response for illegal transfers.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; power of two, at least 4
BASE_ADDR, 32'h0000_0000, byte base address; aligned to MEM_WORDS*4
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; 0..15
PRIV_WORDS, 0, the lowest PRIV_WORDS words require HPROT[1]=1; 0 disables the check

Ports:
hclk  in  1  AHB clock; all state updates on the rising edge
hreset_n  in  1  asynchronous active-low reset
hsel_s  in  1  slave select
haddr_s  in  32  byte address
htrans_s  in  2  transfer type; bit 1 set means NONSEQ or SEQ
hwrite_s  in  1  1 = write
hsize_s  in  3  transfer size
hprot_s  in  4  protection; bit 1 = privileged
hwdata_s  in  32  write data, valid in the data phase
hready_s  in  1  bus-wide HREADY
hreadyout_s  out  1  slave ready
hresp_s  out  1  0 = OKAY, 1 = ERROR
hrdata_s  out  32  read data

Behaviour:
- Reset: hreadyout_s=1, hresp_s=0, hrdata_s=0, state=IDLE, counter=0. SRAM contents are not reset.
- Accept: an address phase is accepted when hsel_s && hready_s && htrans_s[1]. An IDLE or BUSY transfer, or hsel_s=0, completes with zero-wait OKAY and leaves no state change.
- Error check at accept: an access is illegal if any of the following holds:
  - hsize_s>2
  - it is misaligned (half with haddr[0]=1; word with haddr[1:0]!=0)
  - the address is outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS)
  - the word index is below PRIV_WORDS and hprot_s[1]=0
- Captured at accept: word index, byte lanes, hwrite, and an error flag.
- Byte lanes: byte = one lane selected by haddr[1:0]; half = lanes {1,0} or {3,2} selected by haddr[1]; word = all four lanes.
- States:
  - IDLE: hreadyout_s=1, hresp_s=0.
  - DATA: hreadyout_s=(cnt==0), hresp_s=0. cnt is loaded with WAIT_STATES at accept and decrements while nonzero.
  - ERR1: hreadyout_s=0, hresp_s=1.
  - ERR2: hreadyout_s=1, hresp_s=1.
- Transitions:
  - IDLE/DATA(cnt==0)/ERR2 + legal accept → DATA.
  - Same states + illegal accept → ERR1.
  - Same states + no accept → IDLE.
  - DATA with cnt!=0 → DATA. No new accept is possible because hready_s=0.
  - ERR1 → ERR2 always.
- Write: the SRAM is updated at the rising edge that ends the data phase (DATA, cnt==0). Only the enabled lanes take hwdata_s; other lanes are unchanged. Erroring writes never modify the SRAM.
- Read: hrdata_s = SRAM[captured index] combinationally while in DATA with a read; otherwise 0. Data is valid in the cycle hreadyout_s=1. All four lanes are returned regardless of size.
- Back-to-back: a read whose address phase overlaps the data phase of a write to the same word returns the new data. The write commits on the edge that starts the read's data phase.
- Reset asserted mid-transfer: outputs return to their reset values immediately; no partial write occurs after reset deassertion.
- hreadyout_s never stays low for more than WAIT_STATES cycles on OKAY, or 1 cycle on ERROR.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF to BASE+0x10, then read BASE+0x10 back-to-back → hreadyout_s stays 1; read data 0xDEADBEEF in the cycle after the read address phase.
- Byte write 0xAA to BASE+0x13 over word 0x11223344 → word reads 0xAA223344. Half write 0x5566 at BASE+0x10 → word reads 0xAA225566.
- WAIT_STATES=3: single read → hreadyout_s=0 for exactly 3 cycles, then 1 with valid data. The next address phase is not accepted during the wait cycles.
- Word access at BASE+0x2 → ERR1 (ready 0, resp 1), then ERR2 (ready 1, resp 1). SRAM is unchanged; a subsequent read returns the old data.
- PRIV_WORDS=4: user-mode (hprot[1]=0) write to BASE+0x8 → ERROR and no update. The same write with hprot[1]=1 → OKAY and the data is stored.
- Read issued with WAIT_STATES=2, hreset_n pulsed low in the first wait cycle → hreadyout_s=1, hresp_s=0, hrdata_s=0 asynchronously. After release, state is IDLE and an IDLE transfer gets OKAY.
